demultiplexer_1_to_2_3bit_buf: RTL

DEMULTIPLEXER_1_TO_2_3BIT_BUF -- requirements
Module: demultiplexer_1_to_2_3bit_buf

---
 rtl/demultiplexer_1_to_2_3bit_buf.sv | 108 ++++++++++
 1 files changed

// File: rtl/demultiplexer_1_to_2_3bit_buf.sv
// 1-to-2 demultiplexer with a small FIFO on each output channel.
// Input handshake: a word on I moves when I_VALID and I_READY are both high
// at a rising CLK edge. It goes to the channel chosen by S. I_READY depends
// only on S and the fullness of the selected channel.
// Output handshake: a word on Yn moves when Yn_VALID and Yn_READY are both
// high at a rising CLK edge. Yn_VALID never depends on Yn_READY, and
// Yn_READY has no effect while Yn_VALID is low.
// A full channel refuses a push even if it is popped in the same cycle
// (pop-then-push is not supported). This keeps I_READY independent of the
// consumers.
// DEPTH must be 2 or 4, so the pointers wrap naturally at the power of two.
module demultiplexer_1_to_2_3bit_buf #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             S,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic             Y0_VALID,
  output logic             Y1_VALID,
  input  logic             Y0_READY,
  input  logic             Y1_READY,
  output logic [3:0]       CNT0,
  output logic [3:0]       CNT1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]            w_full;
  logic [1:0]            w_valid;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic [1:0]            w_out_ready;
  logic [1:0][WIDTH-1:0] w_head;
  logic [1:0][3:0]       w_cnt;

  assign w_out_ready = {Y1_READY, Y0_READY};

  // The push side only looks at the channel that S selects.
  assign I_READY   = S ? ~w_full[1] : ~w_full[0];
  assign w_push[0] = I_VALID & I_READY & ~S;
  assign w_push[1] = I_VALID & I_READY & S;
  assign w_pop     = w_valid & w_out_ready;

  assign Y0       = w_head[0];
  assign Y1       = w_head[1];
  assign Y0_VALID = w_valid[0];
  assign Y1_VALID = w_valid[1];
  assign CNT0     = w_cnt[0];
  assign CNT1     = w_cnt[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [3:0]       r_cnt;

    assign w_full[ch]  = (r_count == FULL_CNT);
    assign w_valid[ch] = (r_count != '0);
    assign w_head[ch]  = r_mem[r_rd_ptr];
    assign w_cnt[ch]   = r_cnt;

    // Storage: cleared on reset so the heads read 0; written only on a push to this channel.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
      end else if (w_push[ch]) begin
        r_mem[r_wr_ptr] <= I;
      end
    end

    // Write pointer, read pointer and occupancy. A push and a pop together leave the count unchanged.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[ch]) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
        if (w_pop[ch])  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
        case ({w_push[ch], w_pop[ch]})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // Accepted-word counter for this channel, wrapping modulo 16.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_cnt <= '0;
      end else if (w_push[ch]) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule
